// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO push-port arbiter.
// Holds the arbiter FSM state encoding and the round-robin index helper.
package fifo_arb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_MAX  = 4;
    localparam int BEAT_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ERROR = 2'd2
    } arb_state_e;

    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/fifo_push_arb_rr_picker.sv
// Combinational round-robin priority encoder: the search starts one past
// last_idx and wraps, so the most recently served requester has lowest priority.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [$clog2(NUM_REQ)-1:0] next_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int cand_s;

    // Scan offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        next_idx = last_idx;
        cand_s   = 0;
        any      = |req;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_s   = rr_wrap(int'(last_idx), off, NUM_REQ);
            next_idx = req[IDX_W'(cand_s)] ? IDX_W'(cand_s) : next_idx;
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// Arbitrates NUM_REQ valid/ready requesters onto a single FIFO push port with
// round-robin grants, bounded bursts, full-flag stalls and a sticky error state.
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          push_req_n,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          push_full,
    input  logic                          push_error,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_vld,
    output logic                          err_flag,
    input  logic                          err_clr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT    = BEAT_CNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX_RST = IDX_W'(NUM_REQ - 1);

    arb_state_e             state_r;
    logic [IDX_W-1:0]       grant_id_r;
    logic [IDX_W-1:0]       last_grant_r;
    logic [BEAT_CNT_W-1:0]  beat_cnt_r;
    logic                   err_flag_r;
    logic                   grant_vld_r;

    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_any_s;
    logic                   sel_valid_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic                   accept_s;
    logic [NUM_REQ-1:0]     ready_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (req_valid),
        .last_idx (last_grant_r),
        .next_idx (pick_idx_s),
        .any      (pick_any_s)
    );

    // Select the granted requester's valid and data word.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_valid_s = (grant_id_r == IDX_W'(i)) ? req_valid[i] : sel_valid_s;
            sel_data_s  = (grant_id_r == IDX_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                    : sel_data_s;
        end
    end

    // Ready goes only to the granted requester and follows the FIFO full flag.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_s[i] = grant_vld_r & (grant_id_r == IDX_W'(i)) & ~push_full;
        end
    end

    assign accept_s   = grant_vld_r & sel_valid_s & ~push_full;
    assign req_ready  = ready_s;
    assign push_req_n = ~accept_s;
    assign data_in    = sel_data_s;
    assign grant_id   = grant_id_r;
    assign grant_vld  = grant_vld_r;
    assign err_flag   = err_flag_r;

    // Arbiter FSM: grant selection, burst counting, stall and error handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_id_r   <= '0;
            last_grant_r <= LAST_IDX_RST;
            beat_cnt_r   <= '0;
            err_flag_r   <= 1'b0;
            grant_vld_r  <= 1'b0;
        end else if (push_error) begin
            // Error wins over every other transition, including err_clr.
            state_r     <= ERROR;
            err_flag_r  <= 1'b1;
            grant_vld_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_id_r  <= pick_idx_s;
                        beat_cnt_r  <= '0;
                        grant_vld_r <= 1'b1;
                        state_r     <= GRANT;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                GRANT: begin
                    if (!sel_valid_s) begin
                        last_grant_r <= grant_id_r;
                        grant_vld_r  <= 1'b0;
                        state_r      <= IDLE;
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_CNT_W'(1);
                        if (beat_cnt_r == LAST_BEAT) begin
                            last_grant_r <= grant_id_r;
                            grant_vld_r  <= 1'b0;
                            state_r      <= IDLE;
                        end else begin
                            state_r      <= GRANT;
                        end
                    end else begin
                        // Full stall: hold grant and beat count.
                        state_r <= GRANT;
                    end
                end
                ERROR: begin
                    if (err_clr) begin
                        err_flag_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= ERROR;
                    end
                end
                default: begin
                    grant_vld_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
